// File: rtl/floppy_sd_responder.sv
// Sector responder: serves 512-byte read/write requests from a byte-wide RAM holding both drive images.
// Build option FLOPPY_SD_WRITE_EN enables memory writes; without it the images are write-protected.
module floppy_sd_responder #(
    parameter int LBA_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LBA_W-1:0] sd_lba_i,
    input  logic [1:0]       sd_rd_i,
    input  logic [1:0]       sd_wr_i,
    output logic             sd_busy_o,
    output logic             sd_done_o,
    output logic [8:0]       sd_addr_o,
    output logic             sd_data_en_o,
    output logic [7:0]       sd_data_out_o,
    input  logic [7:0]       sd_data_in_i,
    input  logic [11:0]      img_sectors0_i,
    input  logic [11:0]      img_sectors1_i,
    output logic [LBA_W+9:0] mem_addr_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic [7:0]       mem_wdata_o,
    input  logic [7:0]       mem_rdata_i,
    input  logic             mem_ready_i
);
    typedef enum logic [2:0] {
        IDLE, RD_FETCH, RD_PRESENT, WR_ADDR, WR_WAIT, WR_STORE, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             drive_q, drive_d;
    logic             oor_q, oor_d;
    logic [11:0]      img_sel;
    logic             store_done;

    logic             busy_q, done_q, den_q, mrd_q;
    logic [8:0]       addr_q;
    logic [7:0]       dout_q, wdata_q;
    logic [LBA_W+9:0] maddr_q;

`ifdef FLOPPY_SD_WRITE_EN
    logic mwr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) mwr_q <= 1'b0;
        else       mwr_q <= (state_d == WR_STORE) && !oor_d;
    end
    assign mem_wr_o   = mwr_q;
    assign store_done = oor_q || mem_ready_i;
`else
    assign mem_wr_o   = 1'b0;
    assign store_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        drive_d = drive_q;
        oor_d   = oor_q;
        img_sel = img_sectors0_i;
        case (state_q)
            IDLE: begin
                if (|sd_rd_i || |sd_wr_i) begin
                    // reads beat writes, drive 0 beats drive 1
                    drive_d = (|sd_rd_i) ? !sd_rd_i[0] : !sd_wr_i[0];
                    img_sel = drive_d ? img_sectors1_i : img_sectors0_i;
                    lba_d   = sd_lba_i;
                    cnt_d   = '0;
                    oor_d   = 12'(sd_lba_i) >= img_sel;
                    state_d = (|sd_rd_i) ? RD_FETCH : WR_ADDR;
                end
            end
            RD_FETCH:   if (oor_q || mem_ready_i) state_d = RD_PRESENT;
            RD_PRESENT: begin
                if (&cnt_q) state_d = DONE;
                else begin
                    cnt_d   = cnt_q + 9'd1;
                    state_d = RD_FETCH;
                end
            end
            WR_ADDR:    state_d = WR_WAIT;
            WR_WAIT:    state_d = WR_STORE;
            WR_STORE: begin
                if (store_done) begin
                    if (&cnt_q) state_d = DONE;
                    else begin
                        cnt_d   = cnt_q + 9'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lba_q   <= '0;
            cnt_q   <= '0;
            drive_q <= 1'b0;
            oor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            den_q   <= 1'b0;
            mrd_q   <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            drive_q <= drive_d;
            oor_q   <= oor_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_q == DONE;
            den_q   <= state_q == RD_PRESENT;
            mrd_q   <= (state_d == RD_FETCH) && !oor_d;
            // read strobe trails RD_PRESENT by a cycle; write address leads the requester's registered read
            if (state_q == RD_PRESENT)  addr_q <= cnt_q;
            else if (state_d == WR_ADDR) addr_q <= cnt_d;
            if (state_q == RD_FETCH && (oor_q || mem_ready_i))
                dout_q <= oor_q ? 8'h00 : mem_rdata_i;
            if (state_q == WR_WAIT) wdata_q <= sd_data_in_i;
            if (state_d == RD_FETCH || state_d == WR_STORE)
                maddr_q <= {drive_d, lba_d, cnt_d};
        end
    end

    assign sd_busy_o     = busy_q;
    assign sd_done_o     = done_q;
    assign sd_addr_o     = addr_q;
    assign sd_data_en_o  = den_q;
    assign sd_data_out_o = dout_q;
    assign mem_addr_o    = maddr_q;
    assign mem_rd_o      = mrd_q;
    assign mem_wdata_o   = wdata_q;
endmodule

// File: tb/tb_floppy_sd_responder.sv
// Scoreboard bench for floppy_sd_responder: expected bytes/memory accesses queued at request time.
module tb_floppy_sd_responder;
`ifdef FLOPPY_SD_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [10:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0, sd_wr = '0;
    logic        sd_busy, sd_done, sd_data_en;
    logic [8:0]  sd_addr;
    logic [7:0]  sd_data_out, sd_data_in = '0;
    logic [11:0] img0 = '0, img1 = '0;
    logic [20:0] mem_addr;
    logic        mem_rd, mem_wr, mem_ready;
    logic [7:0]  mem_wdata, mem_rdata;

    int n_chk = 0, n_bad = 0;
    int cyc = 0, wait_cyc = 0, wcnt = 0;
    int n_done = 0, n_den = 0, n_mrd = 0, n_mwr = 0;
    int first_den = -1, done_cyc = -1;
    logic [16:0] rd_q[$];   // {sd_addr, sd_data_out}
    logic [28:0] mem_q[$];  // {mem_addr, wdata}

    floppy_sd_responder #(.LBA_W(11)) dut (
        .clk_i(clk), .rst_i(rst), .sd_lba_i(sd_lba), .sd_rd_i(sd_rd), .sd_wr_i(sd_wr),
        .sd_busy_o(sd_busy), .sd_done_o(sd_done), .sd_addr_o(sd_addr),
        .sd_data_en_o(sd_data_en), .sd_data_out_o(sd_data_out), .sd_data_in_i(sd_data_in),
        .img_sectors0_i(img0), .img_sectors1_i(img1), .mem_addr_o(mem_addr),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // requester returns ~sd_addr one cycle late; memory acks after wait_cyc cycles
    always @(posedge clk) sd_data_in <= ~sd_addr[7:0];
    always @(posedge clk) wcnt <= ((mem_rd || mem_wr) && !mem_ready) ? wcnt + 1 : 0;
    assign mem_ready = (mem_rd || mem_wr) && (wcnt >= wait_cyc);
    assign mem_rdata = mem_ready ? mem_addr[7:0] : 8'h5a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({sd_busy, sd_done, sd_addr, sd_data_en, sd_data_out,
                    mem_addr, mem_rd, mem_wr, mem_wdata});
    endfunction

    // monitor
    initial begin
        logic        prev_den, prev_pend;
        logic [20:0] prev_maddr;
        logic [28:0] e;
        prev_den = 1'b0; prev_pend = 1'b0; prev_maddr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_den) chk("den_gap", 64'(sd_data_en), 64'(0));
                if (prev_pend) chk("rd_hold", 64'({mem_rd, mem_addr}), 64'({1'b1, prev_maddr}));
                if (sd_data_en) begin
                    n_den++;
                    if (first_den < 0) first_den = cyc;
                    if (rd_q.size() == 0) chk("rd_unexp", 64'(1), 64'(0));
                    else chk("rd_byte", 64'({sd_addr, sd_data_out}), 64'(rd_q.pop_front()));
                end
                if (mem_ready && mem_rd) begin
                    n_mrd++;
                    if (mem_q.size() == 0) chk("mrd_unexp", 64'(1), 64'(0));
                    else begin
                        e = mem_q.pop_front();
                        chk("mrd_addr", 64'(mem_addr), 64'(e[28:8]));
                    end
                end
                if (mem_ready && mem_wr) begin
                    n_mwr++;
                    if (mem_q.size() == 0) chk("mwr_unexp", 64'(1), 64'(0));
                    else chk("mwr", 64'({mem_addr, mem_wdata}), 64'(mem_q.pop_front()));
                end
                if (sd_done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
            prev_den   = sd_data_en && !rst;
            prev_pend  = mem_rd && !mem_ready && !rst;
            prev_maddr = mem_addr;
        end
    end

    task automatic xfer(input bit wr, input bit drv, input int lba, input bit oor,
                        input bit req, input bit lat);
        int  t0, bcyc, st, r0, w0;
        bit  ok;
        for (int n = 0; n < 512; n++) begin
            if (!wr) begin
                rd_q.push_back({9'(n), oor ? 8'h00 : 8'(n)});
                if (!oor) mem_q.push_back({drv, 11'(lba), 9'(n), 8'h00});
            end else if (!oor && WR_EN) begin
                mem_q.push_back({drv, 11'(lba), 9'(n), ~8'(n)});
            end
        end
        st = n_done; r0 = n_mrd; w0 = n_mwr; first_den = -1; bcyc = 0;
        if (req) begin
            @(posedge clk); #1;
            sd_lba = 11'(lba);
            if (wr) sd_wr[drv] = 1'b1;
            else    sd_rd[drv] = 1'b1;
        end
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (sd_busy) begin ok = 1'b1; bcyc = cyc; end
        end
        chk("busy_rise", 64'(ok), 64'(1));
        if (wr) sd_wr[drv] = 1'b0;
        else    sd_rd[drv] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk); #1;
            if (n_done != st) ok = 1'b1;
        end
        chk("done_seen", 64'(ok), 64'(1));
        chk("rd_left", 64'(rd_q.size()), 64'(0));
        chk("mem_left", 64'(mem_q.size()), 64'(0));
        chk("mrd_cnt", 64'(n_mrd - r0), 64'((!wr && !oor) ? 512 : 0));
        chk("mwr_cnt", 64'(n_mwr - w0), 64'((wr && !oor && WR_EN) ? 512 : 0));
        if (lat) begin
            chk("busy_lat", 64'(bcyc - t0), 64'(1));
            chk("den_lat", 64'(first_den - t0), 64'(3));
            chk("done_lat", 64'(done_cyc - t0), 64'(1026));
        end
        rd_q.delete();
        mem_q.delete();
    endtask

    initial begin
        int  st, d0;
        bit  ok;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", outs(), 64'(0));
        rst = 1'b0;

        // zero-wait read, drive 0
        img0 = 12'd1600; img1 = 12'd1600;
        xfer(1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1);
        // write, drive 1, last sector
        xfer(1'b1, 1'b1, 1599, 1'b0, 1'b1, 1'b0);
        // out of range: lba equal to sector count, then empty image
        img0 = 12'd800;
        xfer(1'b0, 1'b0, 800, 1'b1, 1'b1, 1'b1);
        img0 = 12'd0;
        xfer(1'b0, 1'b0, 800, 1'b1, 1'b1, 1'b1);
        img0 = 12'd1600;

        // priority: all pending at once, serviced rd0, rd1, wr0
        @(posedge clk); #1;
        sd_lba = 11'd7; sd_rd = 2'b11; sd_wr = 2'b01;
        xfer(1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0);

        // backpressure
        wait_cyc = 3;
        xfer(1'b0, 1'b0, 9, 1'b0, 1'b1, 1'b0);
        wait_cyc = 0;

        // reset at byte 200 of a read
        st = n_done; d0 = n_den;
        for (int n = 0; n < 512; n++) begin
            rd_q.push_back({9'(n), 8'(n)});
            mem_q.push_back({1'b0, 11'd3, 9'(n), 8'h00});
        end
        @(posedge clk); #1;
        sd_lba = 11'd3; sd_rd = 2'b01;
        @(posedge clk); #1;
        sd_rd = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk); #1;
            if (n_den - d0 >= 201) ok = 1'b1;
        end
        chk("reach_b200", 64'(ok), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outs", outs(), 64'(0));
        rst = 1'b0;
        rd_q.delete();
        mem_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_done", 64'(n_done - st), 64'(0));
        xfer(1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b1);

        chk("done_total", 64'(n_done), 64'(9));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/floppy_sd_responder.md
# floppy_sd_responder

Responder end of the floppy track buffer's sector request interface. Accepts per-drive 512-byte sector read/write requests (`sd_lba`, `sd_rd`, `sd_wr`), asserts busy, and streams sector bytes with `sd_addr`/`sd_data_en`. On writes it collects bytes from the requester. Sits between the track buffer and a byte-wide backing memory holding both drive images; replaces the SD card path in simulation and in RAM-image builds.

## Interface
Parameters:
- `LBA_W`, 11: sector address width; matches the track buffer.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `sd_lba` in LBA_W: sector number within the selected image.
- `sd_rd` in 2: read request, one bit per drive (bit0 = int, bit1 = ext).
- `sd_wr` in 2: write request, one bit per drive.
- `sd_busy` out 1: request accepted and in progress.
- `sd_done` out 1: one-cycle pulse at completion.
- `sd_addr` out 9: byte index within the sector.
- `sd_data_en` out 1: read-data strobe; `sd_data_out` is valid for `sd_addr`.
- `sd_data_out` out 8: read data to the requester.
- `sd_data_in` in 8: write data from the requester, registered one cycle after `sd_addr`.
- `img_sectors0` in 12: sector count of the drive-0 image; 0 means no image.
- `img_sectors1` in 12: sector count of the drive-1 image.
- `mem_addr` out 21: backing address {drive, lba, byte}.
- `mem_rd` out 1: memory read request, held until `mem_ready`.
- `mem_wr` out 1: memory write request, held until `mem_ready`.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data, valid while `mem_ready` is high.
- `mem_ready` in 1: memory acknowledge.

## Operation
States: IDLE, RD_FETCH, RD_PRESENT, WR_ADDR, WR_WAIT, WR_STORE, DONE.

- **IDLE**
  - Requests are level-sampled, and only in IDLE.
  - Priority: `sd_rd` over `sd_wr`; drive 0 over drive 1.
  - On acceptance: latch drive, op and lba; set `sd_busy` = 1 and byte counter = 0.
  - Go to RD_FETCH or WR_ADDR.
- **Range check** (done at latch): in range iff lba < img_sectors[drive], comparison zero-extended to 12 bits.
  - Out-of-range read: return 0x00 for every byte with no memory access.
  - Out-of-range write: discard data with no memory access.
  - Either way the full 512-byte sequence and `sd_done` still occur.
- **RD_FETCH**
  - Drive `mem_addr` = {drive, lba, n}, `mem_rd` = 1.
  - On `mem_ready`: register `mem_rdata` into `sd_data_out`, drop `mem_rd`, go to RD_PRESENT.
- **RD_PRESENT**
  - One cycle with `sd_data_en` = 1 and `sd_addr` = n.
  - If n = 511 go to DONE; else n += 1 and go to RD_FETCH.
- **WR_ADDR**: `sd_addr` = n for one cycle.
- **WR_WAIT**: hold `sd_addr`; absorbs the requester's registered read.
- **WR_STORE**
  - Capture `sd_data_in` into `mem_wdata` on entry.
  - Hold `mem_wr` = 1 until `mem_ready`.
  - Then go to DONE if n = 511, else n += 1 and go to WR_ADDR.
- **DONE**
  - `sd_busy` = 0 and `sd_done` = 1 for one cycle, then IDLE.
  - The next request can be accepted in the cycle after DONE.
- **Requester obligation:** drop its `sd_rd`/`sd_wr` while `sd_busy` is high. A request still high in IDLE after DONE is treated as a new request.
- **Requests during busy** are ignored, including changes to `sd_lba`, which is not re-sampled.
- **Byte counter** is 9 bits and ends exactly at 511; no wrap occurs inside a sector.

## Timing
- **Reset** (and `rst` mid-transfer): return to IDLE at the next edge. All outputs = 0: `sd_busy`, `sd_done`, `sd_addr`, `sd_data_en`, `sd_data_out`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata`. A partially written sector stays partially written.
- **Busy latency:** `sd_busy` rises 1 cycle after the request is first seen high in IDLE.
- **Read throughput:** 2 cycles/byte minimum (`mem_ready` in the same cycle as `mem_rd`), plus memory wait cycles. An out-of-range read is 2 cycles/byte.
- **Write throughput:** 3 cycles/byte minimum plus memory waits.
- **`sd_data_en`** is never asserted on two consecutive cycles.
- **Full 512-byte read,** zero-wait memory: first `sd_data_en` at cycle 3 after the request; `sd_done` at cycle 1026.

## Configuration
- **`FLOPPY_SD_WRITE_EN` defined:** write path as above.
- **Not defined:** images are write-protected.
  - WR_STORE issues no `mem_wr`; `mem_wr` is tied 0 and the state takes 1 cycle per byte.
  - The 512-byte `sd_addr` sequence, `sd_busy` and `sd_done` are unchanged, so the requester's dirty flush completes.

## Test plan
- **Read, zero-wait memory:** drive-0 image of 1600 sectors; `sd_rd` = 01, lba = 5; memory returns addr[7:0] → 512 `sd_data_en` strobes, byte n = n[7:0], `mem_addr` = {0, 5, n}, one `sd_done`.
- **Write:** `sd_wr` = 10, lba = 1599; requester returns ~`sd_addr`[7:0] one cycle late → 512 `mem_wr` at {1, 1599, n} with data ~n[7:0]. Without `FLOPPY_SD_WRITE_EN`: zero `mem_wr`, `sd_done` still pulses.
- **Out of range:** lba = 800 with `img_sectors0` = 800 → 512 bytes of 0x00, no `mem_rd`. With `img_sectors0` = 0 the same result.
- **Priority:** `sd_rd` = 11 and `sd_wr` = 01 in the same cycle → drive-0 read serviced; after DONE the still-high requests are serviced in order.
- **Memory backpressure:** `mem_ready` delayed 3 cycles per byte → `mem_rd` held, `sd_addr` monotonic, data is correct.
- **Reset mid-transfer:** `rst` at byte 200 of a read → next cycle all outputs 0, no `sd_done`; a new request is then serviced from byte 0.
